// File: rtl/arb_mux2_rr_pkg.sv
// arb_mux2_rr_pkg: state encodings and helpers shared by the round-robin arbiter
package arb_mux2_rr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } state_t;

    function automatic state_t own_state(input logic owner);
        return owner ? ST_OWN1 : ST_OWN0;
    endfunction

endpackage

// File: rtl/arb_mux2_rr_mux.sv
// mux2_1_w: parameterised W-bit 2:1 data multiplexer
module mux2_1_w #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_d0,
    input  logic [W-1:0] i_d1,
    input  logic         i_sel,
    output logic [W-1:0] o_y
);

    // pick d1 when select is high, d0 otherwise
    always @* begin
        o_y = i_sel ? i_d1 : i_d0;
    end

endmodule

// File: rtl/arb_mux2_rr.sv
// arb_mux2_rr: two-requester round-robin arbiter owning a shared 2:1 data path
module arb_mux2_rr
    import arb_mux2_rr_pkg::*;
#(
    parameter int W     = 8,
    parameter int BURST = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic [W-1:0] d0,
    input  logic         req1,
    input  logic [W-1:0] d1,
    input  logic         ready,
    output logic         gnt0,
    output logic         gnt1,
    output logic         valid,
    output logic [W-1:0] out,
    output logic         sel
);

    localparam logic [7:0] LAST_BEAT = 8'(BURST - 1);

    state_t     r_state, w_state_nxt;
    logic       r_sel, w_sel_nxt;
    logic       r_last, w_last_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;
    logic       w_own, w_busy, w_reqx, w_reqy;
    logic       w_enter, w_enter_own;

    assign w_own  = r_state == ST_OWN1;
    assign w_busy = r_state == ST_OWN0 || r_state == ST_OWN1;
    assign w_reqx = w_own ? req1 : req0;
    assign w_reqy = w_own ? req0 : req1;

    assign valid = w_busy && w_reqx;
    assign gnt0  = r_state == ST_OWN0 && req0 && ready;
    assign gnt1  = r_state == ST_OWN1 && req1 && ready;
    assign sel   = r_sel;

    mux2_1_w #(.W(W)) u_mux (
        .i_d0  (d0),
        .i_d1  (d1),
        .i_sel (r_sel),
        .o_y   (out)
    );

    // next owner, burst counter and select; handing the path over loads sel/last and clears cnt
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_enter     = 1'b0;
        w_enter_own = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_enter     = req0 || req1;
                w_enter_own = (req0 && req1) ? !r_last : req1;
            end
            ST_OWN0, ST_OWN1: begin
                if (!w_reqx) begin
                    w_enter     = w_reqy;
                    w_enter_own = !w_own;
                    w_state_nxt = ST_IDLE;
                end else if (ready) begin
                    if (r_cnt == LAST_BEAT) begin
                        w_enter     = w_reqy;
                        w_enter_own = !w_own;
                        w_cnt_nxt   = 8'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_enter) begin
            w_state_nxt = own_state(w_enter_own);
            w_sel_nxt   = w_enter_own;
            w_last_nxt  = w_enter_own;
            w_cnt_nxt   = 8'd0;
        end
    end

    // arbitration state register, cleared immediately by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_sel   <= 1'b0;
            r_last  <= 1'b1;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_arb_mux2_rr.sv
// tb_arb_mux2_rr: directed checks of the round-robin arbiter with BURST=4
module tb_arb_mux2_rr;

    logic       clk = 1'b0;
    logic       reset, req0, req1, ready;
    logic [7:0] d0, d1, out;
    logic       gnt0, gnt1, valid, sel;
    int         n_vec = 0;
    int         n_err = 0;
    logic [11:0] got;

    arb_mux2_rr #(.W(8), .BURST(4)) dut (
        .clk   (clk),
        .reset (reset),
        .req0  (req0),
        .d0    (d0),
        .req1  (req1),
        .d1    (d1),
        .ready (ready),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .valid (valid),
        .out   (out),
        .sel   (sel)
    );

    always #5 clk = ~clk;

    assign got = {valid, gnt0, gnt1, sel, out};

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // reset state, async reset while requester 1 owns the path, first tie goes to requester 0
    task automatic test_reset();
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; ready = 1'b0;
        d0 = 8'h11; d1 = 8'h22;
        #1;
        n_vec++;
        if (got !== {4'b0000, 8'h11}) begin n_err++; $display("FAIL reset_state: got %h want %h", got, {4'b0000, 8'h11}); end
        repeat (2) cyc();
        reset = 1'b0;
        req1 = 1'b1; ready = 1'b1;
        #1;
        n_vec++;
        if (got !== {4'b0000, 8'h11}) begin n_err++; $display("FAIL idle_latency: got %h want %h", got, {4'b0000, 8'h11}); end
        cyc();
        n_vec++;
        if (got !== {4'b1011, 8'h22}) begin n_err++; $display("FAIL own1_before_reset: got %h want %h", got, {4'b1011, 8'h22}); end
        #2;
        reset = 1'b1;
        #1;
        n_vec++;
        if (got !== {4'b0000, 8'h11}) begin n_err++; $display("FAIL async_reset: got %h want %h", got, {4'b0000, 8'h11}); end
        req0 = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        n_vec++;
        if (got !== {4'b0000, 8'h11}) begin n_err++; $display("FAIL post_reset_idle: got %h want %h", got, {4'b0000, 8'h11}); end
        cyc();
        n_vec++;
        if (got !== {4'b1100, 8'h11}) begin n_err++; $display("FAIL first_tie: got %h want %h", got, {4'b1100, 8'h11}); end
        req0 = 1'b0; req1 = 1'b0;
        cyc();
    endtask

    // lone requester keeps the path past the burst limit
    task automatic test_single();
        req0 = 1'b1; d0 = 8'hA5; ready = 1'b1;
        #1;
        n_vec++;
        if (got !== {4'b0000, 8'hA5}) begin n_err++; $display("FAIL single_idle: got %h want %h", got, {4'b0000, 8'hA5}); end
        cyc();
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (got !== {4'b1100, 8'hA5}) begin n_err++; $display("FAIL single_beat%0d: got %h want %h", i, got, {4'b1100, 8'hA5}); end
            cyc();
        end
        req0 = 1'b0;
        cyc();
        n_vec++;
        if (got !== {4'b0000, 8'hA5}) begin n_err++; $display("FAIL single_release: got %h want %h", got, {4'b0000, 8'hA5}); end
    endtask

    // continuous contention alternates groups of four beats with no idle cycle
    task automatic test_contention();
        logic        own;
        logic [11:0] exp;
        req0 = 1'b1; req1 = 1'b1; ready = 1'b1; d0 = 8'h0A; d1 = 8'hB1;
        cyc();
        for (int i = 0; i < 16; i++) begin
            own = ((i / 4) % 2) == 0;
            exp = {1'b1, !own, own, own, own ? 8'hB1 : 8'h0A};
            n_vec++;
            if (got !== exp) begin n_err++; $display("FAIL contention_beat%0d: got %h want %h", i, got, exp); end
            cyc();
        end
        req0 = 1'b0; req1 = 1'b0;
        cyc();
    endtask

    // stall holds owner, data and count; waiting requester gets the path after the remaining beats
    task automatic test_backpressure();
        req0 = 1'b1; ready = 1'b1; d0 = 8'h3C;
        cyc();
        n_vec++;
        if (got !== {4'b1100, 8'h3C}) begin n_err++; $display("FAIL bp_first_beat: got %h want %h", got, {4'b1100, 8'h3C}); end
        cyc();
        ready = 1'b0; req1 = 1'b1; d1 = 8'h77;
        #1;
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (got !== {4'b1000, 8'h3C}) begin n_err++; $display("FAIL bp_stall%0d: got %h want %h", i, got, {4'b1000, 8'h3C}); end
            cyc();
        end
        ready = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (got !== {4'b1100, 8'h3C}) begin n_err++; $display("FAIL bp_resume%0d: got %h want %h", i, got, {4'b1100, 8'h3C}); end
            cyc();
        end
        n_vec++;
        if (got !== {4'b1011, 8'h77}) begin n_err++; $display("FAIL bp_switch: got %h want %h", got, {4'b1011, 8'h77}); end
    endtask

    // owner 1 withdraws after two beats; owner 0 takes over directly
    task automatic test_early_release();
        cyc();
        n_vec++;
        if (got !== {4'b1011, 8'h77}) begin n_err++; $display("FAIL er_beat2: got %h want %h", got, {4'b1011, 8'h77}); end
        cyc();
        req1 = 1'b0;
        #1;
        n_vec++;
        if (got !== {4'b0001, 8'h77}) begin n_err++; $display("FAIL er_drop: got %h want %h", got, {4'b0001, 8'h77}); end
        cyc();
        n_vec++;
        if (got !== {4'b1100, 8'h3C}) begin n_err++; $display("FAIL er_handover: got %h want %h", got, {4'b1100, 8'h3C}); end
    endtask

    // owner 0 withdraws while stalled: no grant, path returns to idle
    task automatic test_withdraw();
        ready = 1'b0;
        #1;
        n_vec++;
        if (got !== {4'b1000, 8'h3C}) begin n_err++; $display("FAIL wd_stall: got %h want %h", got, {4'b1000, 8'h3C}); end
        req0 = 1'b0;
        #1;
        n_vec++;
        if (got !== {4'b0000, 8'h3C}) begin n_err++; $display("FAIL wd_drop: got %h want %h", got, {4'b0000, 8'h3C}); end
        cyc();
        req0 = 1'b1;
        #1;
        n_vec++;
        if (got !== {4'b0000, 8'h3C}) begin n_err++; $display("FAIL wd_idle: got %h want %h", got, {4'b0000, 8'h3C}); end
        cyc();
        n_vec++;
        if (got !== {4'b1000, 8'h3C}) begin n_err++; $display("FAIL wd_regrant: got %h want %h", got, {4'b1000, 8'h3C}); end
        req0 = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_early_release();
        test_withdraw();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
